// File: rtl/ram_burst_pkg.sv
// ram_burst_pkg
// Shared definitions for the RAM burst initiator: FSM state encoding and
// default geometry of the attached single-port RAM (128 x 32).
package ram_burst_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// ram_burst_addr_gen
// Address pointer and beat counter for one burst.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load         capture load_addr/load_len (command accepted)
//   advance      one beat transferred: ptr+1 (wraps), remaining-1
//   load_addr    burst start address
//   load_len     burst beat count, 0..2**Addr_width
//   ptr          current RAM address
//   last         remaining == 1, i.e. the current beat is the final one
module ram_burst_addr_gen
    import ram_burst_pkg::*;
#(
    parameter int Addr_width = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [Addr_width-1:0] load_addr,
    input  logic [Addr_width:0]   load_len,
    output logic [Addr_width-1:0] ptr,
    output logic                  last
);

    logic [Addr_width:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
        end else if (load) begin
            ptr       <= load_addr;
            remaining <= load_len;
        end else if (advance) begin
            // ptr has exactly Addr_width bits, so the increment wraps naturally
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
        end
    end

    assign last = (remaining == (Addr_width+1)'(1));

endmodule

// File: rtl/ram_burst_master.sv
// ram_burst_master
// Initiator for a single-port RAM (sync write, combinational read). Accepts
// burst commands over valid/ready; write bursts stream wr_* beats into the
// RAM, read bursts stream RAM words out on rd_* with backpressure.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    direction, start address, beat count
//   wr_valid/wr_ready, wr_data      write-data stream
//   rd_valid/rd_ready, rd_data      read-data stream
//   busy, done                      burst in progress, one-cycle completion pulse
//   ram_we, ram_address, ram_d      RAM control (sole driver)
//   ram_q                           RAM read data
module ram_burst_master
    import ram_burst_pkg::*;
#(
    parameter int Data_width = DATA_WIDTH_DEF,
    parameter int Addr_width = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [Addr_width-1:0] cmd_addr,
    input  logic [Addr_width:0]   cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [Data_width-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [Data_width-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_we,
    output logic [Addr_width-1:0] ram_address,
    output logic [Data_width-1:0] ram_d,
    input  logic [Data_width-1:0] ram_q
);

    state_t                state, state_nxt;
    logic                  load, advance, last;
    logic [Addr_width-1:0] ptr;

    ram_burst_addr_gen #(.Addr_width(Addr_width)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .load_addr (cmd_addr),
        .load_len  (cmd_len),
        .ptr       (ptr),
        .last      (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) state_nxt = DONE;
                    else if (cmd_write) state_nxt = WRITE;
                    else state_nxt = READ;
                end
            end
            WRITE: if (wr_valid && last) state_nxt = DONE;
            READ:  if (rd_ready && last) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // cmd_ready is gated by rst so no command looks accepted while reset is held
        cmd_ready = (state == IDLE) && !rst;
        wr_ready  = (state == WRITE);
        rd_valid  = (state == READ);
        ram_we    = (state == WRITE) && wr_valid;
        done      = (state == DONE);
        busy      = (state != IDLE);
        load      = cmd_ready && cmd_valid;
        advance   = ((state == WRITE) && wr_valid) || ((state == READ) && rd_ready);
    end

    assign ram_address = ptr;
    assign ram_d       = wr_data;
    assign rd_data     = ram_q;

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator side of the team's single-port RAM interface (clk, we, address, d, q; synchronous write, combinational read, default 128x32).
- Accepts burst commands (start address, length, direction) over a valid/ready command port.
- Write bursts move a valid/ready input stream into the RAM; read bursts stream RAM words out with backpressure.
- Sits between datapath/DMA logic and one RAM instance. It is the only driver of that RAM's we/address/d.

Parameters:
- Data_width, 32, bits per RAM word.
- Addr_width, 7, RAM address bits (depth 2**Addr_width).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  Addr_width  burst start address.
- cmd_len  input  Addr_width+1  beat count, 0..2**Addr_width.
- wr_valid  input  1  write-data beat offered.
- wr_ready  output  1  write beat accepted when wr_valid & wr_ready.
- wr_data  input  Data_width  write-data word.
- rd_valid  output  1  read beat offered.
- rd_ready  input  1  consumer accepts read beat.
- rd_data  output  Data_width  read-data word.
- busy  output  1  burst in progress (state != IDLE).
- done  output  1  one-cycle pulse when a burst completes.
- ram_we  output  1  RAM write enable.
- ram_address  output  Addr_width  RAM address.
- ram_d  output  Data_width  RAM write data.
- ram_q  input  Data_width  RAM read data (combinational from ram_address).

Behaviour:
- Registers:
  - state in {IDLE, WRITE, READ, DONE}.
  - ptr (Addr_width bits).
  - remaining (Addr_width+1 bits).
- Async reset: state=IDLE, ptr=0, remaining=0.
- Outputs during reset: busy=0, done=0, ram_we=0, wr_ready=0, rd_valid=0, cmd_ready=0 (cmd_ready = state==IDLE & ~rst), ram_address=0.
- Combinational outputs:
  - ram_address = ptr in all states.
  - ram_d = wr_data.
  - rd_data = ram_q.
  - wr_ready = state==WRITE.
  - rd_valid = state==READ.
  - ram_we = state==WRITE & wr_valid.
  - done = state==DONE.
  - busy = state!=IDLE.
- IDLE:
  - On command handshake: ptr<=cmd_addr, remaining<=cmd_len.
  - Next state: DONE if cmd_len==0; else WRITE if cmd_write; else READ.
  - cmd_* are ignored outside IDLE.
- WRITE:
  - Each wr handshake writes wr_data to mem[ptr] at that clock edge.
  - Then ptr<=ptr+1 modulo 2**Addr_width, remaining<=remaining-1.
  - If remaining==1 at the handshake, go to DONE.
  - Cycles with wr_valid=0 hold ptr/remaining and do not write.
- READ:
  - rd_data reflects mem[ptr]; ram_we=0.
  - On rd_ready: ptr+1 (wrap), remaining-1; remaining==1 -> DONE.
  - While rd_ready=0, ptr and rd_data are held stable (no writes occur).
- DONE: one cycle, then IDLE.
- Latency and throughput:
  - Command accepted at edge N; first beat possible in cycle N+1.
  - One beat per cycle maximum.
  - done is high in the cycle after the final beat edge; cmd_ready returns the cycle after done.
  - Minimum command-to-command spacing is len+2 cycles.
- Boundaries:
  - Address wraps 2**Addr_width-1 -> 0.
  - cmd_len = 2**Addr_width covers the whole memory and ends with ptr back at cmd_addr.
  - cmd_len=0 performs no RAM access but still pulses done.
- Reset mid-burst: burst is abandoned, ram_we drops immediately (asynchronously), no done pulse, memory contents are not restored.

Decomposition:
- Package ram_burst_pkg: state enum (IDLE/WRITE/READ/DONE), default Data_width/Addr_width constants.
- One natural sub-module, ram_burst_addr_gen:
  - Holds ptr and remaining.
  - Inputs: load, advance.
  - Output: last (remaining==1).
  - The FSM drives load and advance.

Test Plan:
- Write cmd addr=5 len=4, wr_valid held high, data 0xA0..0xA3 -> ram_we high 4 consecutive cycles at addresses 5,6,7,8; done pulses the cycle after the 4th beat; busy high from cycle after accept through done.
- Read cmd addr=5 len=4, rd_ready toggling 1,0,1,0... -> rd_data 0xA0,0xA1,0xA2,0xA3 in order; rd_data/ram_address stable during stalls; ram_we never high; done after 4th accepted beat.
- Wrap: write addr=126 len=4 data 1..4, then read addr=126 len=4 -> writes land at 126,127,0,1; readback yields 1,2,3,4.
- cmd_len=0 write -> accept at cycle 0, done=1 and busy=1 in cycle 1, cmd_ready=1 in cycle 2; ram_we never asserted.
- Write len=3 with wr_valid pattern 1,0,0,1,1 -> exactly 3 ram_we cycles at consecutive addresses; no address advance on idle cycles.
- Assert rst after 2 of 4 write beats -> ram_we=0 and busy=0 immediately; no done pulse; after release cmd_ready=1 and a new read of len=2 completes normally.
